spi_periph: RTL

SPI peripheral (target) endpoint, the far end of our SD/SPI controller link: receives SCLK/CS/MOSI from an external SPI controller and drives MISO. Fixed mode 0 (SCLK idle low, sample on rising edge, shift on falling edge), MSB first, 8-bit frames, matching the controller's framing. All SPI inputs are oversampled in the system clock domain. The host side is a one-byte TX holding buffer and an RX data register with valid/read handshake.

---
 rtl/spi_periph.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_periph.sv
// SPI peripheral (target) endpoint: mode 0, MSB first, 8-bit frames.
// All SPI pins are oversampled in the clk_i domain (clk_i >= 8x SCLK).
// Ports:
//   clk_i, rst_ni          system clock, async active-low reset
//   spi_clk_i/cs_i/mosi_i  asynchronous SPI inputs from the controller
//   spi_miso_o             peripheral-to-controller data
//   tx_data_i/tx_we_i      host write into the one-byte TX buffer
//   tx_full_o, tx_udr_o    buffer holds unsent byte / underrun pulse
//   rx_data_o, rx_val_o    last received byte and its unread flag
//   rx_rd_i, rx_ovf_o      host read strobe / sticky overrun flag
//   busy_o                 frame in progress (synchronized CS asserted)
`timescale 1ns/1ps
module spi_periph #(
  parameter logic [7:0] DEFAULT_TX = 8'hFF,
  parameter logic       MISO_IDLE  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_clk_i,
  input  logic       spi_cs_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_we_i,
  output logic       tx_full_o,
  output logic       tx_udr_o,
  output logic [7:0] rx_data_o,
  output logic       rx_val_o,
  input  logic       rx_rd_i,
  output logic       rx_ovf_o,
  output logic       busy_o
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizers: [0],[1] are the 2-FF chain, [2] is the edge-detect copy
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;
  logic mosi_s;

  state_t              state_q,   state_d;
  logic [DATA_W-1:0]   tx_sr_q,   tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q,   rx_sr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   tx_buf_q,  tx_buf_d;
  logic                tx_full_q, tx_full_d;
  logic                tx_udr_q,  tx_udr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_val_q,  rx_val_d;
  logic                rx_ovf_q,  rx_ovf_d;
  logic                miso_q,    miso_d;
  logic                busy_q,    busy_d;

  logic                load;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   rx_byte;

  // Input synchronization
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk_i};
      cs_q   <= {cs_q[1:0], spi_cs_i};
      mosi_q <= {mosi_q[0], spi_mosi_i};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign mosi_s    = mosi_q[1];
  assign rx_byte   = {rx_sr_q[DATA_W-2:0], mosi_s};

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      tx_buf_q  <= '0;
      tx_full_q <= 1'b0;
      tx_udr_q  <= 1'b0;
      rx_data_q <= '0;
      rx_val_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      miso_q    <= MISO_IDLE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
      tx_buf_q  <= tx_buf_d;
      tx_full_q <= tx_full_d;
      tx_udr_q  <= tx_udr_d;
      rx_data_q <= rx_data_d;
      rx_val_q  <= rx_val_d;
      rx_ovf_q  <= rx_ovf_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, shift, byte-load and host handshake logic
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    tx_buf_d  = tx_buf_q;
    tx_full_d = tx_full_q;
    tx_udr_d  = 1'b0;
    rx_data_d = rx_data_q;
    rx_val_d  = rx_val_q;
    rx_ovf_d  = rx_ovf_q;
    miso_d    = miso_q;
    load      = 1'b0;
    load_val  = DEFAULT_TX;

    // Read strobe first so a coinciding byte completion wins for rx_val
    if (rx_rd_i) begin
      rx_val_d = 1'b0;
      rx_ovf_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        miso_d    = MISO_IDLE;
        bit_cnt_d = '0;
        if (cs_fall) begin
          load    = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Abort any partial byte; bit counter realigns for the next frame
          state_d   = IDLE;
          miso_d    = MISO_IDLE;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          rx_sr_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d = rx_byte;
            rx_val_d  = 1'b1;
            if (rx_val_q && !rx_rd_i) begin
              rx_ovf_d = 1'b1;
            end
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b1};
            miso_d  = tx_sr_q[DATA_W-2];
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Byte load from the TX buffer; host writes bypass or refill it
    if (load) begin
      if (tx_full_q) begin
        load_val  = tx_buf_q;
        tx_full_d = tx_we_i;
        if (tx_we_i) begin
          tx_buf_d = tx_data_i;
        end
      end else if (tx_we_i) begin
        load_val = tx_data_i;
      end else begin
        load_val = DEFAULT_TX;
        tx_udr_d = 1'b1;
      end
      tx_sr_d = load_val;
      miso_d  = load_val[DATA_W-1];
    end else if (tx_we_i) begin
      tx_buf_d  = tx_data_i;
      tx_full_d = 1'b1;
    end

    busy_d = (state_d == ACTIVE);
  end

  assign spi_miso_o = miso_q;
  assign tx_full_o  = tx_full_q;
  assign tx_udr_o   = tx_udr_q;
  assign rx_data_o  = rx_data_q;
  assign rx_val_o   = rx_val_q;
  assign rx_ovf_o   = rx_ovf_q;
  assign busy_o     = busy_q;

endmodule
